// File: rtl/priority_encoder_4to2_seq_if.sv
// Request/index bundle for priority_encoder_4to2_seq.
// The encoder connects to the slave modport. The producer/consumer side connects to the master modport.
interface priority_encoder_4to2_seq_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_idx;
    logic [NUM_REQ-1:0] pending;
    logic               busy;

    modport master (
        output en, req, out_ready,
        input  out_valid, out_idx, pending, busy
    );

    modport slave (
        input  en, req, out_ready,
        output out_valid, out_idx, pending, busy
    );
endinterface

// File: rtl/priority_encoder_4to2_seq.sv
// Registered request encoder. Multi-hot requests collect in a pending register and drain one index per transfer.
// Define ROUND_ROBIN_EN to get rotating priority. The default build uses fixed lowest-index priority.
module priority_encoder_4to2_seq #(
    parameter int NUM_REQ = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    priority_encoder_4to2_seq_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] pend_p0;
    logic               vld_p1;
    logic [IDX_W-1:0]   idx_p1;
    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_REQ-1:0] clr;
    logic               any_pend;
    logic               load;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;

    function automatic logic [IDX_W-1:0] sel(input logic [NUM_REQ-1:0] vec,
                                             input logic [IDX_W-1:0]   start);
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int p;
            p = (int'(start) + k) % NUM_REQ;
            if (!found && vec[p]) begin
                idx   = IDX_W'(p);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign sel_idx = sel(pend_p0, ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (load)
            ptr <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
    end
`else
    function automatic logic [IDX_W-1:0] sel(input logic [NUM_REQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (vec[i]) idx = IDX_W'(i);
        return idx;
    endfunction

    assign sel_idx = sel(pend_p0);
`endif

    always_comb begin
        any_pend = |pend_p0;
        load     = any_pend & (~vld_p1 | bus.out_ready);
        clr      = load ? (NUM_REQ'(1) << sel_idx) : '0;
    end

    // Stage p0: capture requests; a new set on a bit overrides its clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend_p0 <= '0;
        else
            pend_p0 <= (pend_p0 & ~clr) | (bus.en ? bus.req : '0);
    end

    // Stage p1: valid/ready output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            idx_p1 <= '0;
        end else if (load) begin
            vld_p1 <= 1'b1;
            idx_p1 <= sel_idx;
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.pending   = pend_p0;
    assign bus.out_valid = vld_p1;
    assign bus.out_idx   = idx_p1;
    assign bus.busy      = vld_p1 | any_pend;
endmodule

// File: tb/tb_priority_encoder_4to2_seq.sv
// Directed self-checking bench for priority_encoder_4to2_seq.
// The expected sequences follow ROUND_ROBIN_EN when the macro is defined.
module tb_priority_encoder_4to2_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    priority_encoder_4to2_seq_if #(.NUM_REQ(4)) bus ();

    priority_encoder_4to2_seq #(.NUM_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.en = 1'b1; bus.req = 4'b1111; bus.out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (bus.pending !== 4'b0000) begin fails++; $display("FAIL reset_pending got=%b want=0000", bus.pending); end
        checks++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
        checks++;
        if (bus.out_idx !== 2'd0) begin fails++; $display("FAIL reset_idx got=%0d want=0", bus.out_idx); end
        checks++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        rst_n = 1'b1; bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_single;
        bus.en = 1'b1; bus.req = 4'b0100; bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.pending !== 4'b0100 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            fails++; $display("FAIL single_e1 pend=%b vld=%b busy=%b want 0100/0/1", bus.pending, bus.out_valid, bus.busy);
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd2 || bus.pending !== 4'b0000) begin
            fails++; $display("FAIL single_e2 vld=%b idx=%0d pend=%b want 1/2/0000", bus.out_valid, bus.out_idx, bus.pending);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL single_e3 vld=%b busy=%b want 0/0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_disabled;
        bus.en = 1'b0; bus.req = 4'b1111; bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.pending !== 4'b0000 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                fails++; $display("FAIL disabled_c%0d pend=%b vld=%b busy=%b want 0000/0/0", i, bus.pending, bus.out_valid, bus.busy);
            end
        end
        bus.req = 4'b0000; bus.en = 1'b1;
    endtask

    task automatic test_multi;
        logic [1:0] exp_idx [3];
        logic [3:0] exp_pend [3];
`ifdef ROUND_ROBIN_EN
        exp_idx  = '{2'd3, 2'd0, 2'd1};
        exp_pend = '{4'b0011, 4'b0010, 4'b0000};
`else
        exp_idx  = '{2'd0, 2'd1, 2'd3};
        exp_pend = '{4'b1010, 4'b1000, 4'b0000};
`endif
        bus.en = 1'b1; bus.req = 4'b1011; bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.pending !== 4'b1011 || bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL multi_capture pend=%b vld=%b want 1011/0", bus.pending, bus.out_valid);
        end
        bus.req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== exp_idx[i] || bus.pending !== exp_pend[i]) begin
                fails++; $display("FAIL multi_t%0d vld=%b idx=%0d pend=%b want 1/%0d/%b", i, bus.out_valid, bus.out_idx, bus.pending, exp_idx[i], exp_pend[i]);
            end
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL multi_end vld=%b busy=%b want 0/0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_backpressure;
        bus.en = 1'b1; bus.req = 4'b0010; bus.out_ready = 1'b0;
        tick();
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd1 || bus.pending !== 4'b0000) begin
            fails++; $display("FAIL bp_load vld=%b idx=%0d pend=%b want 1/1/0000", bus.out_valid, bus.out_idx, bus.pending);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd1) begin
            fails++; $display("FAIL bp_hold vld=%b idx=%0d want 1/1", bus.out_valid, bus.out_idx);
        end
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.pending !== 4'b0010 || bus.out_valid !== 1'b1 || bus.out_idx !== 2'd1) begin
            fails++; $display("FAIL bp_repend pend=%b vld=%b idx=%0d want 0010/1/1", bus.pending, bus.out_valid, bus.out_idx);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd1 || bus.pending !== 4'b0000) begin
            fails++; $display("FAIL bp_second vld=%b idx=%0d pend=%b want 1/1/0000", bus.out_valid, bus.out_idx, bus.pending);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL bp_drain vld=%b busy=%b want 0/0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset_mid;
        bus.en = 1'b1; bus.req = 4'b0010; bus.out_ready = 1'b0;
        tick();
        bus.req = 4'b1100;
        tick();
        bus.req = 4'b0000;
        checks++;
        if (bus.pending !== 4'b1100 || bus.out_valid !== 1'b1 || bus.out_idx !== 2'd1) begin
            fails++; $display("FAIL rmid_setup pend=%b vld=%b idx=%0d want 1100/1/1", bus.pending, bus.out_valid, bus.out_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pending !== 4'b0000 || bus.out_valid !== 1'b0 || bus.out_idx !== 2'd0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL rmid_async pend=%b vld=%b idx=%0d busy=%b want all 0", bus.pending, bus.out_valid, bus.out_idx, bus.busy);
        end
        tick();
        rst_n = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                fails++; $display("FAIL rmid_after_c%0d vld=%b busy=%b want 0/0", i, bus.out_valid, bus.busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_idx [6];
`ifdef ROUND_ROBIN_EN
        exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`else
        exp_idx = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        bus.en = 1'b1; bus.req = 4'b1111; bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== exp_idx[i]) begin
                fails++; $display("FAIL b2b_t%0d vld=%b idx=%0d want 1/%0d", i, bus.out_valid, bus.out_idx, exp_idx[i]);
            end
        end
        bus.req = 4'b0000;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pending !== 4'b0000) begin
            fails++; $display("FAIL b2b_drain vld=%b busy=%b pend=%b want 0/0/0000", bus.out_valid, bus.busy, bus.pending);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        bus.en = 1'b0; bus.req = 4'b0000; bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_disabled();
        test_multi();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
